cam_pixel_capture: RTL and testbench

- Front-end capture stage for the OV7670 parallel bus. It sits between the camera pins (p_clock, vsync, href, p_data) and the frame-buffer write port that the camera/GPIO unit and NPU read.
- Oversamples the camera bus in the system clock domain and assembles byte pairs into RGB565 pixels.
- Decimates by DECIM in both axes and emits one buffer write per kept pixel, plus a frame-done pulse.

---
 rtl/cam_pkg.sv | 39 +++
 rtl/cam_input_sync.sv | 45 ++++
 rtl/cam_pixel_capture.sv | 222 ++++++++++++++++++++++
 tb/tb_cam_pixel_capture.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the OV7670 pixel capture front-end.
// Optional feature macro: CAM_GRAYSCALE_EN (see cam_pixel_capture).
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DONE
  } cap_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // BT.601-style luma weights scaled by 256
  localparam logic [7:0] LUMA_R = 8'd77;
  localparam logic [7:0] LUMA_G = 8'd150;
  localparam logic [7:0] LUMA_B = 8'd29;

  // Expands each channel to 8 bits by bit replication, then forms the
  // weighted sum; the weights total 256 so the sum always fits 16 bits.
  function automatic logic [7:0] rgb565_to_luma(input rgb565_t px);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    r8  = {px.r, px.r[4:2]};
    g8  = {px.g, px.g[5:4]};
    b8  = {px.b, px.b[4:2]};
    sum = ({8'h00, r8} * {8'h00, LUMA_R}) +
          ({8'h00, g8} * {8'h00, LUMA_G}) +
          ({8'h00, b8} * {8'h00, LUMA_B});
    return sum[15:8];
  endfunction

endpackage

// File: rtl/cam_input_sync.sv
// Two-flop synchronizer for the camera bus. All 11 camera bits share one
// flop chain so p_clock, vsync, href and p_data stay mutually aligned; a
// third stage on the control bits provides the edge strobes.
module cam_input_sync
  import cam_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       p_clock,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] p_data,
  output logic       href_s,
  output logic [7:0] data_s,
  output logic       pclk_rise,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href_fall
);

  logic [10:0] meta;
  logic [10:0] sync;
  logic [2:0]  prev;

  // Synchronizer chain plus one delayed copy of p_clock/vsync/href for edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= {p_clock, vsync, href, p_data};
      sync <= meta;
      prev <= sync[10:8];
    end
  end

  assign href_s     = sync[8];
  assign data_s     = sync[7:0];
  assign pclk_rise  = sync[10] & ~prev[2];
  assign vsync_rise = sync[9] & ~prev[1];
  assign vsync_fall = ~sync[9] & prev[1];
  assign href_fall  = ~sync[8] & prev[0];

endmodule

// File: rtl/cam_pixel_capture.sv
// OV7670 capture front-end: oversampled camera bus -> RGB565 pixels ->
// DECIM x DECIM decimation -> frame-buffer writes plus a frame-done pulse.
// Optional feature macro: CAM_GRAYSCALE_EN converts each kept pixel to
// 8-bit luma through one extra pipeline stage.
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DECIM = 4,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          p_clock,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    p_data,
  output logic          busy,
  output logic          frame_done,
  output logic          short_frame,
  output logic          line_err,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data
);

  localparam int OUT_W = IMG_W / DECIM;
  localparam int OUT_H = IMG_H / DECIM;
  localparam int LAST  = OUT_W * OUT_H - 1;
  localparam int RW    = $clog2(IMG_H + 1);
  localparam int CW    = $clog2(IMG_W + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(LAST);
  localparam logic [AW-1:0] OUT_W_A   = AW'(OUT_W);
  localparam logic [RW-1:0] ROW_MASK  = RW'(DECIM - 1);
  localparam logic [RW-1:0] ROW_LIM   = RW'(IMG_H);
  localparam logic [CW-1:0] COL_MASK  = CW'(DECIM - 1);
  localparam logic [CW-1:0] COL_LIM   = CW'(IMG_W);

  cap_state_t    state;
  cap_state_t    next_state;

  logic          href_s;
  logic [7:0]    data_s;
  logic          pclk_rise;
  logic          vsync_rise;
  logic          vsync_fall;
  logic          href_fall;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          byte_phase;
  logic [7:0]    hi_byte;
  logic [AW-1:0] addr_cnt;
  logic [AW-1:0] line_base;
  logic [AW-1:0] next_base;

  logic          pix_en;
  logic [AW-1:0] pix_addr;
  rgb565_t       pix_data;

  logic          row_live;
  logic          row_kept;
  logic          byte_ok;

  cam_input_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .p_clock    (p_clock),
    .vsync      (vsync),
    .href       (href),
    .p_data     (p_data),
    .href_s     (href_s),
    .data_s     (data_s),
    .pclk_rise  (pclk_rise),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_fall  (href_fall)
  );

  assign row_live = (row < ROW_LIM);
  assign row_kept = row_live && ((row & ROW_MASK) == '0);
  assign byte_ok  = pclk_rise && href_s && row_live;

  // Start of the next kept row, pinned to the last valid address
  always_comb begin
    next_base = line_base + OUT_W_A;
    if (int'(line_base) + OUT_W > LAST) begin
      next_base = LAST_ADDR;
    end
  end

  // Capture state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and status decode
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = ARM;
        end
      end
      ARM: begin
        busy = 1'b1;
        if (vsync_fall) begin
          next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        busy = 1'b1;
        if (vsync_rise) begin
          next_state = DONE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Byte pairing, row/column tracking, running address and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row         <= '0;
      col         <= '0;
      byte_phase  <= 1'b0;
      hi_byte     <= '0;
      addr_cnt    <= '0;
      line_base   <= '0;
      pix_en      <= 1'b0;
      pix_addr    <= '0;
      pix_data    <= '0;
      short_frame <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      pix_en <= 1'b0;
      if (state == IDLE && start) begin
        short_frame <= 1'b0;
        line_err    <= 1'b0;
      end
      if (state == ARM && vsync_fall) begin
        row        <= '0;
        col        <= '0;
        byte_phase <= 1'b0;
        addr_cnt   <= '0;
        line_base  <= '0;
      end
      if (state == CAPTURE) begin
        if (vsync_rise) begin
          if (row_live) begin
            short_frame <= 1'b1;
          end
        end else if (href_fall) begin
          row <= (row == '1) ? row : row + 1'b1;
          col <= '0;
          if (byte_phase) begin
            line_err   <= 1'b1;
            byte_phase <= 1'b0;
          end
          if (row_kept) begin
            line_base <= next_base;
            addr_cnt  <= next_base;
          end else begin
            addr_cnt <= line_base;
          end
        end else if (byte_ok) begin
          if (col >= COL_LIM) begin
            line_err <= 1'b1;
          end else if (!byte_phase) begin
            hi_byte    <= data_s;
            byte_phase <= 1'b1;
          end else begin
            byte_phase <= 1'b0;
            col        <= (col == '1) ? col : col + 1'b1;
            if (row_kept && ((col & COL_MASK) == '0)) begin
              pix_en   <= 1'b1;
              pix_addr <= addr_cnt;
              pix_data <= {hi_byte, data_s};
              addr_cnt <= (addr_cnt == LAST_ADDR) ? addr_cnt : addr_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef CAM_GRAYSCALE_EN
  // Luma conversion stage; address travels alongside to stay aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= pix_en;
      if (pix_en) begin
        wr_addr <= pix_addr;
        wr_data <= {8'h00, rgb565_to_luma(pix_data)};
      end
    end
  end
`else
  assign wr_en   = pix_en;
  assign wr_addr = pix_addr;
  assign wr_data = pix_data;
`endif

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench for cam_pixel_capture on an 8x4 image decimated by 2.
// Builds with or without CAM_GRAYSCALE_EN; expected data follows the macro.
module tb_cam_pixel_capture;

  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int DECIM = 2;
  localparam int AW    = 4;
`ifdef CAM_GRAYSCALE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          p_clock;
  logic          vsync;
  logic          href;
  logic [7:0]    p_data;
  logic          busy;
  logic          frame_done;
  logic          short_frame;
  logic          line_err;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          last_rise   = 0;
  int          done_count  = 0;
  int          write_count = 0;
  int          max_addr    = 0;
  logic [15:0] seen [0:15];

  cam_pixel_capture #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .DECIM (DECIM),
    .AW    (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .p_clock     (p_clock),
    .vsync       (vsync),
    .href        (href),
    .p_data      (p_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .short_frame (short_frame),
    .line_err    (line_err),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected buffer word for a captured RGB565 pixel
  function automatic logic [15:0] exp_data(input logic [15:0] pix);
`ifdef CAM_GRAYSCALE_EN
    int r5, g6, b5, r8, g8, b8, y;
    r5 = int'(pix[15:11]);
    g6 = int'(pix[10:5]);
    b5 = int'(pix[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    y  = (77 * r8 + 150 * g8 + 29 * b8) / 256;
    return 16'(y);
`else
    return pix;
`endif
  endfunction

  function automatic logic [15:0] pix_val(input int row, input int col, input bit special);
    if (special && row == 0 && col == 0) return 16'hFFFF;
    if (special && row == 0 && col == 2) return 16'hF800;
    return 16'(16'h0100 * row + col);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every write and tracks frame_done
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) done_count++;
      if (wr_en) begin
        write_count++;
        if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
        seen[wr_addr] = wr_data;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_write: got addr %0h data %0h, required no write", wr_addr, wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check_output("wr_addr", 32'(wr_addr), 32'(e.addr));
          check_output("wr_data", 32'(wr_data), 32'(e.data));
          check_output("wr_latency", 32'(cyc - last_rise), 32'(LAT));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    p_data = b;
    repeat (4) @(negedge clk);
    p_clock   = 1'b1;
    last_rise = cyc;
    repeat (4) @(negedge clk);
    p_clock = 1'b0;
  endtask

  // One href-qualified line; expected writes are queued as bytes go out
  task automatic send_line(input int row, input int nbytes, input bit special);
    href = 1'b1;
    for (int b = 0; b < nbytes; b++) begin
      int          col;
      logic [15:0] pix;
      wr_t         e;
      col = b / 2;
      pix = pix_val(row, col, special);
      if ((b % 2) == 1 && col < IMG_W && row < IMG_H && (row % DECIM) == 0 && (col % DECIM) == 0) begin
        e.addr = AW'((row / DECIM) * (IMG_W / DECIM) + col / DECIM);
        e.data = exp_data(pix);
        exp_q.push_back(e);
      end
      send_byte((b % 2) == 0 ? pix[15:8] : pix[7:0]);
    end
    href = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic arm_frame();
    write_count = 0;
    max_addr    = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Whole frame: line 0 has line0_bytes bytes, the rest 16 bytes each
  task automatic apply_stimulus(input int nlines, input int line0_bytes, input bit special);
    int d0;
    int t;
    d0 = done_count;
    arm_frame();
    for (int r = 0; r < nlines; r++) begin
      send_line(r, (r == 0) ? line0_bytes : 2 * IMG_W, special);
    end
    vsync = 1'b1;
    t = 0;
    while (done_count == d0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    check_output("frame_done_count", 32'(done_count - d0), 32'd1);
    check_output("busy_after", 32'(busy), 32'd0);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    p_clock = 1'b0;
    vsync   = 1'b1;
    href    = 1'b0;
    p_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_frame_done", 32'(frame_done), 32'd0);
    check_output("rst_short_frame", 32'(short_frame), 32'd0);
    check_output("rst_line_err", 32'(line_err), 32'd0);
    check_output("rst_wr_en", 32'(wr_en), 32'd0);
    check_output("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_output("rst_wr_data", 32'(wr_data), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] full frame");
    apply_stimulus(4, 16, 1'b0);
    check_output("full_writes", 32'(write_count), 32'd8);
    check_output("full_short", 32'(short_frame), 32'd0);
    check_output("full_line_err", 32'(line_err), 32'd0);
    check_output("full_addr5", 32'(seen[5]), 32'(exp_data(16'h0202)));

    $display("[TB] short frame");
    apply_stimulus(2, 16, 1'b0);
    check_output("short_writes", 32'(write_count), 32'd4);
    check_output("short_flag", 32'(short_frame), 32'd1);

    $display("[TB] odd line");
    apply_stimulus(4, 13, 1'b0);
    check_output("odd_writes", 32'(write_count), 32'd7);
    check_output("odd_line_err", 32'(line_err), 32'd1);
    check_output("odd_short_cleared", 32'(short_frame), 32'd0);

    $display("[TB] over-long line and extra line");
    apply_stimulus(5, 20, 1'b0);
    check_output("long_writes", 32'(write_count), 32'd8);
    check_output("long_line_err", 32'(line_err), 32'd1);
    check_output("long_addr_bound", 32'(max_addr > 7), 32'd0);

    $display("[TB] special pixels");
    apply_stimulus(4, 16, 1'b1);
    check_output("special_writes", 32'(write_count), 32'd8);
`ifdef CAM_GRAYSCALE_EN
    check_output("gray_ffff", 32'(seen[0]), 32'h00FF);
    check_output("gray_f800", 32'(seen[1]), 32'h004C);
`else
    check_output("raw_ffff", 32'(seen[0]), 32'hFFFF);
    check_output("raw_f800", 32'(seen[1]), 32'hF800);
`endif

    $display("[TB] reset mid-capture");
    begin
      int d0;
      d0 = done_count;
      arm_frame();
      send_line(0, 12, 1'b0);
      repeat (4) @(negedge clk);
      check_output("abort_writes", 32'(write_count), 32'd3);
      rst = 1'b1;
      #1;
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_wr_en", 32'(wr_en), 32'd0);
      check_output("abort_wr_addr", 32'(wr_addr), 32'd0);
      check_output("abort_wr_data", 32'(wr_data), 32'd0);
      repeat (3) @(negedge clk);
      vsync = 1'b1;
      exp_q.delete();
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check_output("abort_no_done", 32'(done_count - d0), 32'd0);
    end
    apply_stimulus(4, 16, 1'b0);
    check_output("after_abort_writes", 32'(write_count), 32'd8);
    check_output("after_abort_addr7", 32'(seen[7]), 32'(exp_data(16'h0206)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
